// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command to APB requester with wait-state timeout
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [2:0]            cmd_prot,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [2:0]            PPROT,
  output logic                  PNSE,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic accept, timeout_hit;
  assign cmd_ready   = state == IDLE && !PRESET;
  assign accept      = cmd_valid && cmd_ready;
  assign timeout_hit = TIMEOUT_CYCLES != 0 && !PREADY && int'(wait_cnt) == TIMEOUT_CYCLES - 1;
  assign PNSE        = 1'b0;
  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = accept ? SETUP : IDLE;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  state_nxt = (PREADY || timeout_hit) ? RESP : ACCESS;
      RESP:    state_nxt = rsp_ready ? IDLE : RESP;
    endcase
  end
  // state register
  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else state <= state_nxt;
  end
  // registered APB strobes, captured command, wait counter and response
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PPROT       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      PSEL      <= state_nxt == SETUP || state_nxt == ACCESS;
      PENABLE   <= state_nxt == ACCESS;
      rsp_valid <= state_nxt == RESP;
      if (accept) begin
        PWRITE   <= cmd_write;
        PADDR    <= cmd_addr;
        PWDATA   <= cmd_wdata;
        PPROT    <= cmd_prot;
        wait_cnt <= '0;
      end else if (state == ACCESS && !PREADY && wait_cnt != '1) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (state == ACCESS && PREADY) begin
        rsp_rdata   <= PWRITE ? '0 : PRDATA;
        rsp_slverr  <= PSLVERR;
        rsp_timeout <= 1'b0;
      end else if (state == ACCESS && timeout_hit) begin
        rsp_rdata   <= '0;
        rsp_slverr  <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: randomized APB requester bench with slave and reference memory models
module tb_apb_master_bridge;
  localparam int T = 16;
  logic PCLK, PRESET;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic [2:0] cmd_prot;
  logic rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
  logic [7:0] rsp_rdata;
  logic [31:0] PADDR;
  logic [2:0] PPROT;
  logic PNSE, PSEL, PENABLE, PWRITE;
  logic [7:0] PWDATA, PRDATA;
  logic PREADY, PSLVERR;
  int checks = 0, failures = 0, cyc = 0;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];

  apb_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(8), .TIMEOUT_CYCLES(T)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout), .PADDR(PADDR), .PPROT(PPROT),
    .PNSE(PNSE), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR));

  initial PCLK = 0;
  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  // runs one command through the bus while acting as the APB slave; reports what was observed
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [7:0] wd, input logic [2:0] pr,
                      input int waits, input logic err, input int bp,
                      output int lat, output int nsel, output int nen, output logic stable,
                      output logic [7:0] rd, output logic se, output logic to, output logic bp_ok,
                      output int acc_cyc);
    int ai = 0;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd; cmd_prot = pr;
    @(posedge PCLK); #1;
    acc_cyc = cyc; cmd_valid = 0;
    lat = 0; nsel = 0; nen = 0; stable = 1; bp_ok = 1;
    while (!rsp_valid && lat < 100) begin
      PREADY = 0; PSLVERR = 0;
      if (PSEL) begin
        nsel++;
        if (PADDR !== a || PWRITE !== wr || PWDATA !== wd || PPROT !== pr) stable = 0;
      end
      if (PSEL && PENABLE) begin
        nen++;
        PREADY = ai >= waits;
        ai++;
        PSLVERR = err && PREADY;
        PRDATA = mem[PADDR[7:0]];
        if (PREADY && wr && !err) mem[PADDR[7:0]] = PWDATA;
      end
      @(posedge PCLK); #1;
      lat++;
    end
    PREADY = 0; PSLVERR = 0;
    rd = rsp_rdata; se = rsp_slverr; to = rsp_timeout;
    if (PSEL || PENABLE || cmd_ready) bp_ok = 0;
    for (int i = 0; i < bp; i++) begin
      @(posedge PCLK); #1;
      if (!rsp_valid || rsp_rdata !== rd || rsp_slverr !== se || rsp_timeout !== to || cmd_ready || PSEL) bp_ok = 0;
    end
    rsp_ready = 1;
    @(posedge PCLK); #1;
    rsp_ready = 0;
  endtask

  task automatic test_reset;
    PRESET = 1; cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h44; cmd_wdata = 8'h5A; cmd_prot = 3'd5;
    for (int i = 0; i < 3; i++) begin
      @(posedge PCLK); #1;
      checks++;
      if ({cmd_ready, PSEL, PENABLE, PWRITE, PNSE, rsp_valid, rsp_slverr, rsp_timeout} !== 8'h0 ||
          PADDR !== 0 || PWDATA !== 0 || PPROT !== 0 || rsp_rdata !== 0) begin
        failures++;
        $display("FAIL reset cyc%0d: ready=%b sel=%b en=%b addr=%h wdata=%h prot=%h rv=%b rd=%h, required all 0",
                 i, cmd_ready, PSEL, PENABLE, PADDR, PWDATA, PPROT, rsp_valid, rsp_rdata);
      end
    end
    PRESET = 0; cmd_valid = 0;
    #1;
    checks++;
    if (cmd_ready !== 1) begin failures++; $display("FAIL reset_release: cmd_ready=%b required 1", cmd_ready); end
  endtask

  task automatic test_write;
    int lat, ns, ne, ac; logic st, se, to, bo; logic [7:0] rd;
    xfer(1, 32'h10, 8'hA5, 3'd2, 1, 0, 0, lat, ns, ne, st, rd, se, to, bo, ac);
    ref_mem[8'h10] = 8'hA5;
    checks++;
    if (ns !== 3 || ne !== 2 || !st) begin failures++; $display("FAIL write_bus: psel=%0d penable=%0d stable=%b required 3 2 1", ns, ne, st); end
    checks++;
    if (rd !== 0 || se !== 0 || to !== 0 || lat !== 3) begin failures++; $display("FAIL write_rsp: rdata=%h slverr=%b tmo=%b lat=%0d required 00 0 0 3", rd, se, to, lat); end
  endtask

  task automatic test_readback;
    int lat, ns, ne, ac; logic st, se, to, bo; logic [7:0] rd;
    xfer(0, 32'h10, 8'h00, 3'd0, 1, 0, 0, lat, ns, ne, st, rd, se, to, bo, ac);
    checks++;
    if (rd !== 8'hA5 || se !== 0 || to !== 0) begin failures++; $display("FAIL readback_rsp: rdata=%h slverr=%b tmo=%b required a5 0 0", rd, se, to); end
    checks++;
    if (lat !== 3 || !st) begin failures++; $display("FAIL readback_timing: lat=%0d stable=%b required 3 1", lat, st); end
  endtask

  task automatic test_slverr;
    int lat, ns, ne, ac; logic st, se, to, bo; logic [7:0] rd;
    xfer(1, 32'h20, 8'h3C, 3'd1, 0, 1, 0, lat, ns, ne, st, rd, se, to, bo, ac);
    checks++;
    if (se !== 1 || to !== 0 || rd !== 0 || lat !== 2) begin failures++; $display("FAIL slverr_rsp: slverr=%b tmo=%b rdata=%h lat=%0d required 1 0 00 2", se, to, rd, lat); end
    xfer(0, 32'h20, 8'h00, 3'd1, 0, 0, 0, lat, ns, ne, st, rd, se, to, bo, ac);
    checks++;
    if (se !== 0 || to !== 0 || rd !== ref_mem[8'h20] || lat !== 2) begin
      failures++; $display("FAIL slverr_next: slverr=%b tmo=%b rdata=%h lat=%0d required 0 0 %h 2", se, to, rd, lat, ref_mem[8'h20]);
    end
  endtask

  task automatic test_timeout;
    int lat, ns, ne, ac; logic st, se, to, bo; logic [7:0] rd;
    xfer(0, 32'h30, 8'h00, 3'd0, 1000, 0, 1, lat, ns, ne, st, rd, se, to, bo, ac);
    checks++;
    if (ne !== T || lat !== T + 1 || !bo) begin failures++; $display("FAIL timeout_len: access=%0d lat=%0d idle_bus=%b required %0d %0d 1", ne, lat, bo, T, T + 1); end
    checks++;
    if (se !== 1 || to !== 1 || rd !== 0) begin failures++; $display("FAIL timeout_rsp: slverr=%b tmo=%b rdata=%h required 1 1 00", se, to, rd); end
    xfer(0, 32'h30, 8'h00, 3'd0, T - 1, 0, 0, lat, ns, ne, st, rd, se, to, bo, ac);
    checks++;
    if (ne !== T || to !== 0 || se !== 0 || rd !== ref_mem[8'h30] || lat !== T + 1) begin
      failures++; $display("FAIL timeout_edge: access=%0d tmo=%b slverr=%b rdata=%h lat=%0d required %0d 0 0 %h %0d", ne, to, se, rd, lat, T, ref_mem[8'h30], T + 1);
    end
  endtask

  task automatic test_backpressure;
    int lat, ns, ne, ac; logic st, se, to, bo; logic [7:0] rd;
    xfer(0, 32'h10, 8'h00, 3'd4, 1, 0, 5, lat, ns, ne, st, rd, se, to, bo, ac);
    checks++;
    if (!bo || rd !== ref_mem[8'h10]) begin failures++; $display("FAIL backpressure: held_stable=%b rdata=%h required 1 %h", bo, rd, ref_mem[8'h10]); end
  endtask

  task automatic test_reset_mid;
    logic bad = 0;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h8; cmd_prot = 0;
    @(posedge PCLK); #1; cmd_valid = 0;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    checks++;
    if (PSEL !== 1 || PENABLE !== 1) begin failures++; $display("FAIL midreset_access: sel=%b en=%b required 1 1", PSEL, PENABLE); end
    PRESET = 1;
    @(posedge PCLK); #1;
    checks++;
    if (PSEL !== 0 || PENABLE !== 0 || rsp_valid !== 0) begin failures++; $display("FAIL midreset_drop: sel=%b en=%b rv=%b required 0 0 0", PSEL, PENABLE, rsp_valid); end
    PRESET = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge PCLK); #1;
      if (rsp_valid || PSEL) bad = 1;
    end
    checks++;
    if (bad || cmd_ready !== 1) begin failures++; $display("FAIL midreset_after: spurious=%b ready=%b required 0 1", bad, cmd_ready); end
  endtask

  task automatic test_back_to_back;
    int lat, ns, ne, ac0, ac1, ac2; logic st, se, to, bo; logic [7:0] rd;
    xfer(0, 32'h1, 8'h0, 3'd0, 0, 0, 0, lat, ns, ne, st, rd, se, to, bo, ac0);
    xfer(0, 32'h2, 8'h0, 3'd0, 0, 0, 0, lat, ns, ne, st, rd, se, to, bo, ac1);
    xfer(0, 32'h3, 8'h0, 3'd0, 0, 0, 0, lat, ns, ne, st, rd, se, to, bo, ac2);
    checks++;
    if (ac1 - ac0 !== 4 || ac2 - ac1 !== 4) begin failures++; $display("FAIL back_to_back: spacing=%0d,%0d required 4,4", ac1 - ac0, ac2 - ac1); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 30; n++) begin
      int lat, ns, ne, ac, w, bp, nacc, e_lat; logic st, se, to, bo, wr, err, e_to, e_se; logic [7:0] rd, wd, e_rd; logic [31:0] a;
      wr = 1'($urandom); wd = 8'($urandom); a = 32'($urandom_range(0, 31));
      w = ($urandom_range(0, 5) == 0) ? $urandom_range(T - 1, T + 4) : $urandom_range(0, 3);
      err = $urandom_range(0, 7) == 0; bp = $urandom_range(0, 2);
      e_to = w >= T; nacc = e_to ? T : w + 1; e_lat = e_to ? T + 1 : w + 2;
      e_se = e_to || err; e_rd = (e_to || wr) ? 8'h0 : ref_mem[a[7:0]];
      xfer(wr, a, wd, 3'($urandom), w, err, bp, lat, ns, ne, st, rd, se, to, bo, ac);
      if (wr && !e_to && !err) ref_mem[a[7:0]] = wd;
      checks++;
      if (rd !== e_rd || se !== e_se || to !== e_to) begin
        failures++; $display("FAIL rand%0d_rsp: rdata=%h slverr=%b tmo=%b required %h %b %b", n, rd, se, to, e_rd, e_se, e_to);
      end
      checks++;
      if (lat !== e_lat || ne !== nacc || ns !== nacc + 1 || !st || !bo) begin
        failures++; $display("FAIL rand%0d_bus: lat=%0d access=%0d sel=%0d stable=%b bp=%b required %0d %0d %0d 1 1", n, lat, ne, ns, st, bo, e_lat, nacc, nacc + 1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = 8'($urandom); ref_mem[i] = mem[i]; end
    rsp_ready = 0; PREADY = 0; PSLVERR = 0; PRDATA = 0;
    test_reset;
    test_write;
    test_readback;
    test_slverr;
    test_timeout;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB requester that turns single-beat commands from an internal valid/ready command port into APB transfers. Each command runs the full SETUP/ACCESS protocol and returns read data and error status on a valid/ready response port. It is the initiator end of the APB bus and drives the APB slave blocks in this codebase. A programmable wait-state timeout keeps a hung slave from stalling the requester.

## Interface
- ADDR_WIDTH, 32, width of cmd_addr and PADDR
- DATA_WIDTH, 8, width of the write and read data paths
- TIMEOUT_CYCLES, 16, maximum number of ACCESS cycles with PREADY low before the transfer is aborted; 0 disables the timeout
- PCLK  in  1  the only clock; all logic is on the rising edge
- PRESET  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_prot  in  3  protection attributes, passed to PPROT
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_slverr  out  1  PSLVERR sampled at completion, or 1 on timeout
- rsp_timeout  out  1  transfer was aborted by timeout
- PADDR  out  ADDR_WIDTH  APB address
- PPROT  out  3  APB protection
- PNSE  out  1  tied to 0
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

## Operation
- **FSM states:** IDLE, SETUP, ACCESS, RESP. The state register is updated only on a PCLK edge.
- **IDLE**
  - cmd_ready = 1 when PRESET is 0.
  - When cmd_valid && cmd_ready, capture cmd_write, cmd_addr, cmd_wdata and cmd_prot into PWRITE, PADDR, PWDATA and PPROT, then go to SETUP.
- **SETUP**
  - PSEL = 1, PENABLE = 0.
  - Always go to ACCESS on the next edge.
- **ACCESS**
  - PSEL = 1, PENABLE = 1.
  - While PREADY = 0, increment the wait counter. The counter is $clog2(TIMEOUT_CYCLES+1) bits wide, saturates, and clears on entry to SETUP.
  - If PREADY = 1 at an edge:
    - For a read, capture PRDATA into rsp_rdata. For a write, rsp_rdata = 0.
    - Set rsp_slverr = PSLVERR and rsp_timeout = 0, then go to RESP.
  - If TIMEOUT_CYCLES ≠ 0, PREADY = 0, and the wait counter equals TIMEOUT_CYCLES−1 at an edge, abort:
    - Set rsp_slverr = 1, rsp_timeout = 1, rsp_rdata = 0, then go to RESP.
  - If PREADY and the timeout condition occur at the same edge, PREADY wins and the transfer completes normally.
- **RESP**
  - PSEL = 0, PENABLE = 0, rsp_valid = 1.
  - rsp_rdata, rsp_slverr and rsp_timeout hold stable until rsp_valid && rsp_ready, then go to IDLE.
- **Address/control hold rule:** PADDR, PWRITE, PWDATA and PPROT stay stable from SETUP through the final ACCESS cycle. They keep their last values in RESP and IDLE.
- **Registered outputs:** all APB outputs and response outputs are registered. cmd_ready is a decode of state == IDLE && !PRESET.
- **Single outstanding transfer:** no new command is accepted until the response has been consumed.

## Timing
- **Reset values:** PSEL, PENABLE, PWRITE, PADDR, PWDATA, PPROT, PNSE, rsp_valid, rsp_rdata, rsp_slverr and rsp_timeout are all 0. cmd_ready is 0 while PRESET = 1. The state is IDLE.
- **Reset during a transfer:** PRESET asserted in any state forces IDLE at the next edge. PSEL and PENABLE drop together, any pending response is discarded, and no partial response is ever presented.
- **Latency for a command accepted at edge N:**
  - SETUP cycle is N..N+1.
  - First ACCESS cycle is N+1..N+2.
  - With PREADY = 1 in the first ACCESS cycle, rsp_valid is high from edge N+2.
  - Each extra wait state adds one cycle.
- **Throughput:** with zero wait states and rsp_ready held at 1, there is one transfer every 4 cycles (SETUP, ACCESS, RESP, IDLE).
- **Wait states:** the APB slaves in this codebase assert PREADY one cycle into ACCESS. This gives 2 ACCESS cycles and rsp_valid at edge N+3.
- **Timeout length:** with PREADY stuck at 0, ACCESS lasts exactly TIMEOUT_CYCLES cycles. rsp_valid rises at edge N+1+TIMEOUT_CYCLES.
- **Response backpressure:** rsp_ready = 0 holds RESP indefinitely, with PSEL = 0 and cmd_ready = 0 throughout.

## Test plan
- **Reset:** PRESET = 1 for 3 cycles with cmd_valid = 1 -> all outputs 0, cmd_ready = 0, no PSEL. After release, cmd_ready = 1.
- **Write:**
  - Stimulus: write addr 0x0000_0010, data 0xA5, slave PREADY on the 2nd ACCESS cycle.
  - Required: PSEL for 3 cycles, PENABLE for the last 2, PADDR = 0x10 and PWDATA = 0xA5 stable throughout.
  - Response: rsp_valid with rsp_slverr = 0, rsp_rdata = 0.
- **Read-back:** read 0x10 after the write above -> PWRITE = 0, rsp_rdata = 0xA5, rsp_slverr = 0. Check rsp_valid at edge N+3.
- **Slave error:** slave returns PSLVERR = 1 with PREADY -> rsp_slverr = 1, rsp_timeout = 0. The next command is accepted normally.
- **Timeout:**
  - Stimulus: TIMEOUT_CYCLES = 16, PREADY tied to 0.
  - Required: exactly 16 ACCESS cycles, then PSEL = 0 and rsp_slverr = 1, rsp_timeout = 1, rsp_rdata = 0.
  - Repeat with PREADY rising in the 16th cycle -> normal completion, rsp_timeout = 0.
- **Backpressure and reset mid-transfer:**
  - Hold rsp_ready = 0 for 5 cycles -> rsp_valid and its data stable, cmd_ready = 0.
  - Separately, assert PRESET during ACCESS -> PSEL and PENABLE are 0 after the next edge and no rsp_valid follows.
